// File: rtl/eth_rx_frame_arbiter.sv
// eth_rx_frame_arbiter: two-port frame-granular store-and-forward arbiter.
// Each RX port buffers whole frames in a private FIFO; a round-robin
// scheduler forwards complete frames only, so output frames never interleave.
// Frames larger than the free buffer space are discarded and counted.
//
// Ports (top):
//   clk, rst                          clock, async active-high reset
//   in0Data/in0DataValid/in0DataLast  port 0 byte stream (no backpressure)
//   in1Data/in1DataValid/in1DataLast  port 1 byte stream (no backpressure)
//   outData/outDataValid/outDataLast  merged registered output stream
//   outPort                           source port of the current output frame
//   drop0Count/drop1Count             saturating dropped-frame counters

// eth_rx_port_fifo: one port's frame buffer, write FSM and drop counter.
// Ports: clk_i, rst_i; data_i/valid_i/last_i input bytes; rd_en_i pops the
// byte at rd_word_o; pending_o flags a committed frame; drop_cnt_o drops.
module eth_rx_port_fifo #(
    parameter int DEPTH = 2048,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic             rd_en_i,
    output logic [8:0]       rd_word_o,
    output logic             pending_o,
    output logic [CNT_W-1:0] drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] WR_IDLE    = 2'd0;
    localparam logic [1:0] WR_FILL    = 2'd1;
    localparam logic [1:0] WR_DISCARD = 2'd2;

    logic [8:0]       mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      start_q, start_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [AW:0]      occ;
    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             we;
    logic             commit;
    logic             pop;

    assign rd_word_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign pending_o  = (cnt_q != '0);
    assign drop_cnt_o = drop_q;

    always_comb begin
        occ      = wr_ptr_q - rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        start_d  = start_q;
        st_d     = st_q;
        drop_d   = drop_q;
        we       = 1'b0;
        commit   = 1'b0;
        if (valid_i) begin
            if (st_q == WR_DISCARD) begin
                if (last_i) st_d = WR_IDLE;
            end else if (!occ[AW]) begin
                // occ never exceeds DEPTH, so a clear MSB means room left
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (st_q == WR_IDLE) start_d = wr_ptr_q;
                if (last_i) begin
                    commit = 1'b1;
                    st_d   = WR_IDLE;
                end else begin
                    st_d = WR_FILL;
                end
            end else begin
                // In WR_IDLE nothing of this frame was written yet,
                // so leaving wr_ptr alone is the rewind.
                if (st_q == WR_FILL) wr_ptr_d = start_q;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
                st_d = last_i ? WR_IDLE : WR_DISCARD;
            end
        end
    end

    assign pop      = rd_en_i & rd_word_o[8];
    assign rd_ptr_d = rd_en_i ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({commit, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            start_q  <= '0;
            cnt_q    <= '0;
            st_q     <= WR_IDLE;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            st_q     <= st_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is not reset; pointers alone define its contents.
    always_ff @(posedge clk_i) begin
        if (we) mem_q[wr_ptr_q[AW-1:0]] <= {last_i, data_i};
    end
endmodule

module eth_rx_frame_arbiter #(
    parameter int DEPTH = 2048,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in0Data,
    input  logic             in0DataValid,
    input  logic             in0DataLast,
    input  logic [7:0]       in1Data,
    input  logic             in1DataValid,
    input  logic             in1DataLast,
    output logic [7:0]       outData,
    output logic             outDataValid,
    output logic             outDataLast,
    output logic             outPort,
    output logic [CNT_W-1:0] drop0Count,
    output logic [CNT_W-1:0] drop1Count
);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_SEND = 1'b1;

    logic [8:0] word0, word1, word;
    logic       pend0, pend1;
    logic       rd_en0, rd_en1;

    logic       state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       out_port_q, out_port_d;

    eth_rx_port_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_port0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_i     (in0Data),
        .valid_i    (in0DataValid),
        .last_i     (in0DataLast),
        .rd_en_i    (rd_en0),
        .rd_word_o  (word0),
        .pending_o  (pend0),
        .drop_cnt_o (drop0Count)
    );

    eth_rx_port_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_port1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_i     (in1Data),
        .valid_i    (in1DataValid),
        .last_i     (in1DataLast),
        .rd_en_i    (rd_en1),
        .rd_word_o  (word1),
        .pending_o  (pend1),
        .drop_cnt_o (drop1Count)
    );

    assign word   = grant_q ? word1 : word0;
    assign rd_en0 = (state_q == S_SEND) && !grant_q;
    assign rd_en1 = (state_q == S_SEND) && grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_port_d   = out_port_q;
        out_valid_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (pend0 || pend1) begin
                // On a tie the port that did not go last wins.
                grant_d = (pend0 && pend1) ? ~last_grant_q : pend1;
                state_d = S_SEND;
            end
        end else begin
            out_valid_d = 1'b1;
            out_data_d  = word[7:0];
            out_last_d  = word[8];
            out_port_d  = grant_q;
            if (word[8]) begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_port_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_port_q   <= out_port_d;
        end
    end

    assign outData      = out_data_q;
    assign outDataValid = out_valid_q;
    assign outDataLast  = out_last_q;
    assign outPort      = out_port_q;
endmodule

// File: tb/tb_eth_rx_frame_arbiter.sv
// Scoreboard bench for eth_rx_frame_arbiter (DEPTH=64, CNT_W=2).
// Stimulus pushes expected bytes; a negedge monitor pops and compares.
module tb_eth_rx_frame_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in0Data = '0;
    logic       in0DataValid = 1'b0;
    logic       in0DataLast = 1'b0;
    logic [7:0] in1Data = '0;
    logic       in1DataValid = 1'b0;
    logic       in1DataLast = 1'b0;
    logic [7:0] outData;
    logic       outDataValid;
    logic       outDataLast;
    logic       outPort;
    logic [1:0] drop0Count;
    logic [1:0] drop1Count;

    eth_rx_frame_arbiter #(.DEPTH(64), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in0Data      (in0Data),
        .in0DataValid (in0DataValid),
        .in0DataLast  (in0DataLast),
        .in1Data      (in1Data),
        .in1DataValid (in1DataValid),
        .in1DataLast  (in1DataLast),
        .outData      (outData),
        .outDataValid (outDataValid),
        .outDataLast  (outDataLast),
        .outPort      (outPort),
        .drop0Count   (drop0Count),
        .drop1Count   (drop1Count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       port;
        logic       last;
        logic [7:0] data;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    logic prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic p, input logic [7:0] start,
                                input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.port = p;
            e.last = (i == len - 1);
            e.data = start + 8'(i);
            expq.push_back(e);
        end
    endtask

    task automatic send_frame(input int p, input logic [7:0] start,
                              input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (p == 0) begin
                in0Data      = start + 8'(i);
                in0DataValid = 1'b1;
                in0DataLast  = (i == len - 1);
            end else begin
                in1Data      = start + 8'(i);
                in1DataValid = 1'b1;
                in1DataLast  = (i == len - 1);
            end
        end
        @(negedge clk);
        if (p == 0) begin
            in0DataValid = 1'b0;
            in0DataLast  = 1'b0;
        end else begin
            in1DataValid = 1'b0;
            in1DataLast  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(expq.size()), 32'd0);
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in0DataValid = 1'b0;
        in0DataLast  = 1'b0;
        in1DataValid = 1'b0;
        in1DataLast  = 1'b0;
        expq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compare every presented byte and the mandatory idle gap.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_last = 1'b0;
        end else begin
            if (prev_last) chk("gap_after_last", 32'(outDataValid), 32'd0);
            if (outDataValid) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got data %0h port %0d, none expected",
                             outData, outPort);
                end else begin
                    e = expq.pop_front();
                    chk("out_port_last_data",
                        32'({outPort, outDataLast, outData}), 32'(e));
                end
            end
            prev_last = outDataValid && outDataLast;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(outDataValid), 32'd0);
        chk("rst_last", 32'(outDataLast), 32'd0);
        chk("rst_data", 32'(outData), 32'd0);
        chk("rst_port", 32'(outPort), 32'd0);
        chk("rst_drop0", 32'(drop0Count), 32'd0);
        chk("rst_drop1", 32'(drop1Count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single 64-byte frame and T+2 latency
        expect_frame(1'b0, 8'h00, 64);
        send_frame(0, 8'h00, 64);
        @(posedge clk);
        #1 chk("lat_t1", 32'(outDataValid), 32'd0);
        @(posedge clk);
        #1 chk("lat_t2", 32'(outDataValid), 32'd1);
        wait_drain();

        // Tie: port 0 first after reset
        do_reset();
        expect_frame(1'b0, 8'h10, 10);
        expect_frame(1'b1, 8'h20, 10);
        fork
            send_frame(0, 8'h10, 10);
            send_frame(1, 8'h20, 10);
        join
        wait_drain();

        // Fairness: A0 B0 A1 B1 A2 B2
        do_reset();
        for (int k = 0; k < 3; k++) begin
            expect_frame(1'b0, 8'h00 + 8'(16 * k), 4);
            expect_frame(1'b1, 8'h80 + 8'(16 * k), 4);
        end
        fork
            begin
                for (int k = 0; k < 3; k++)
                    send_frame(0, 8'h00 + 8'(16 * k), 4);
            end
            begin
                for (int k = 0; k < 3; k++)
                    send_frame(1, 8'h80 + 8'(16 * k), 4);
            end
        join
        wait_drain();

        // Overflow on port 1
        do_reset();
        expect_frame(1'b1, 8'hF0, 8);
        send_frame(1, 8'h00, 65);
        send_frame(1, 8'hF0, 8);
        wait_drain();
        chk("ovf_drop1", 32'(drop1Count), 32'd1);
        chk("ovf_drop0", 32'(drop0Count), 32'd0);

        // Exact DEPTH frame, then 1-byte frame
        do_reset();
        expect_frame(1'b0, 8'h40, 64);
        send_frame(0, 8'h40, 64);
        wait_drain();
        expect_frame(1'b0, 8'h5A, 1);
        send_frame(0, 8'h5A, 1);
        wait_drain();
        chk("bnd_drop0", 32'(drop0Count), 32'd0);

        // Saturation with CNT_W=2
        for (int k = 0; k < 5; k++) begin
            send_frame(0, 8'h00, 65);
            if (k == 2) chk("sat_drop0_3", 32'(drop0Count), 32'd3);
        end
        chk("sat_drop0_5", 32'(drop0Count), 32'd3);
        chk("sat_drop1", 32'(drop1Count), 32'd0);
        expect_frame(1'b0, 8'h33, 3);
        send_frame(0, 8'h33, 3);
        wait_drain();

        // Reset in the middle of a 32-byte output frame
        expect_frame(1'b0, 8'h60, 32);
        send_frame(0, 8'h60, 32);
        repeat (10) @(posedge clk);
        #1 chk("mid_valid", 32'(outDataValid), 32'd1);
        #1 rst = 1'b1;
        expq.delete();
        #1 chk("mrst_valid", 32'(outDataValid), 32'd0);
        chk("mrst_data", 32'(outData), 32'd0);
        chk("mrst_port", 32'(outPort), 32'd0);
        chk("mrst_drop0", 32'(drop0Count), 32'd0);
        chk("mrst_drop1", 32'(drop1Count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_frame(1'b1, 8'hC0, 4);
        send_frame(1, 8'hC0, 4);
        wait_drain();
        repeat (40) @(posedge clk);

        chk("leftover", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
